// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and press-pulse three push-buttons
// Up/down auto-repeat while held; center pulses once per press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic       IN_clk,
  input  logic       IN_rst_n,
  input  logic       IN_up_button,
  input  logic       IN_down_button,
  input  logic       IN_center_button,
  output logic       OUT_up_pulse,
  output logic       OUT_down_pulse,
  output logic       OUT_center_pulse,
  output logic [2:0] OUT_button_state
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_P = (MAX_A > REPEAT_RATE_CYCLES) ? MAX_A : REPEAT_RATE_CYCLES;
  localparam int CW    = $clog2(MAX_P);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

  // Channel index: 0 = up, 1 = down, 2 = center
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    stable_q, stable_d;
  logic [CW-1:0] db_cnt_q [3];
  logic [CW-1:0] db_cnt_d [3];
  logic [2:0]    rise;
  state_t        state_q [2];
  state_t        state_d [2];
  logic [CW-1:0] rpt_cnt_q [2];
  logic [CW-1:0] rpt_cnt_d [2];
  logic [2:0]    pulse_q, pulse_d;

  assign raw = {IN_center_button, IN_down_button, IN_up_button};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press is detected on the next-state value so the pulse leaves with the level change.
  assign rise = stable_d & ~stable_q;

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            pulse_d[i]   = 1'b1;
            state_d[i]   = ST_DELAY;
            rpt_cnt_d[i] = '0;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          // A release wins over a terminal count landing on the same edge.
          if (!stable_d[i]) begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == ((state_q[i] == ST_DELAY) ? DLY_LAST : RPT_LAST)) begin
            pulse_d[i]   = 1'b1;
            state_d[i]   = ST_REPEAT;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i]   = ST_IDLE;
          rpt_cnt_d[i] = '0;
        end
      endcase
    end
    pulse_d[2] = rise[2];
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      db_cnt_q  <= '{default: '0};
      state_q   <= '{default: ST_IDLE};
      rpt_cnt_q <= '{default: '0};
      pulse_q   <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign OUT_up_pulse     = pulse_q[0];
  assign OUT_down_pulse   = pulse_q[1];
  assign OUT_center_pulse = pulse_q[2];
  assign OUT_button_state = stable_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner
// Reference model tracks debounced levels and hold times since each press.
module tb_button_conditioner;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk = 1'b0;
  logic       rst_n, up, down, ctr;
  logic       up_p, down_p, ctr_p;
  logic [2:0] bstate;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: two-sample input delay, debounced level, press time per channel
  logic [2:0] smp1, smp2, lvl, act, exp_p;
  int         run  [3];
  int         pcyc [3];

  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
  ) dut (
    .IN_clk(clk), .IN_rst_n(rst_n),
    .IN_up_button(up), .IN_down_button(down), .IN_center_button(ctr),
    .OUT_up_pulse(up_p), .OUT_down_pulse(down_p), .OUT_center_pulse(ctr_p),
    .OUT_button_state(bstate)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    smp1 = '0; smp2 = '0; lvl = '0; act = '0; exp_p = '0;
    for (int c = 0; c < 3; c++) begin
      run[c] = 0; pcyc[c] = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] x);
    logic [2:0] prev;
    int t;
    prev = lvl;
    for (int c = 0; c < 3; c++) begin
      if (smp2[c] != lvl[c]) begin
        run[c]++;
        if (run[c] == D) begin
          lvl[c] = ~lvl[c];
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
      smp2[c]  = smp1[c];
      smp1[c]  = x[c];
      exp_p[c] = 1'b0;
      if (lvl[c] && !prev[c]) begin
        act[c]  = 1'b1;
        pcyc[c] = cyc;
      end
      if (!lvl[c]) act[c] = 1'b0;
      if (act[c]) begin
        t = cyc - pcyc[c];
        if (t == 0) exp_p[c] = 1'b1;
        else if (c != 2 && t >= RD && (t - RD) % RR == 0) exp_p[c] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input string tag);
    logic [2:0] x;
    logic       in_rst;
    x      = {ctr, down, up};
    in_rst = !rst_n;
    @(posedge clk);
    cyc++;
    if (in_rst) model_reset();
    else model_step(x);
    #1;
    chk(tag, {26'd0, ctr_p, down_p, up_p, bstate}, {26'd0, exp_p, lvl});
  endtask

  task automatic run_count(input string tag, input int n, input int ch, output int cnt, output int first);
    logic [2:0] p;
    cnt = 0; first = -1;
    for (int i = 1; i <= n; i++) begin
      tick(tag);
      p = {ctr_p, down_p, up_p};
      if (p[ch]) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  initial begin
    int cnt, first, rel, ucnt, dcnt, ccnt;
    int offs [$];
    rst_n = 1'b0; up = 1'b0; down = 1'b0; ctr = 1'b0;
    model_reset();
    #1;
    chk("reset_state", {28'd0, ctr_p, down_p, up_p, bstate[0]}, 32'd0);
    chk("reset_levels", {29'd0, bstate}, 32'd0);
    tick("in_reset"); tick("in_reset");
    rst_n = 1'b1;
    repeat (3) tick("idle");

    // Clean center press and release
    ctr = 1'b1;
    run_count("center_press", 10, 2, cnt, first);
    chk("center_cnt", cnt, 1);
    chk("center_lat", first, 6);
    ctr = 1'b0;
    rel = -1;
    for (int i = 1; i <= 10; i++) begin
      tick("center_rel");
      if (rel < 0 && !bstate[2]) rel = i;
      chk("center_rel_nopulse", {31'd0, ctr_p}, 32'd0);
    end
    chk("center_rel_lat", rel, 6);

    // Bounce then hold
    up = 1'b1; tick("bounce"); tick("bounce");
    up = 1'b0; tick("bounce"); tick("bounce");
    up = 1'b1; tick("bounce"); tick("bounce");
    up = 1'b0; tick("bounce"); tick("bounce");
    up = 1'b1;
    run_count("bounce_hold", 14, 0, cnt, first);
    chk("bounce_cnt", cnt, 1);
    chk("bounce_lat", first, 6);
    up = 1'b0;
    repeat (10) tick("bounce_rel");

    // Short bounce only
    up = 1'b1; tick("short"); tick("short");
    up = 1'b0; tick("short"); tick("short");
    up = 1'b1; tick("short");
    up = 1'b0;
    run_count("short_bounce", 15, 0, cnt, first);
    chk("short_cnt", cnt, 0);

    // Auto-repeat; release timed so the fall coincides with a terminal count
    down = 1'b1;
    run_count("rep_press", 6, 1, cnt, first);
    chk("rep_press_lat", first, 6);
    for (int i = 1; i <= 54; i++) begin
      tick("rep_hold");
      if (down_p) offs.push_back(i);
    end
    chk("rep_cnt", offs.size(), 5);
    for (int k = 0; k < offs.size() && k < 5; k++) chk("rep_offset", offs[k], RD + k * RR);
    down = 1'b0;
    run_count("rep_release", 15, 1, cnt, first);
    chk("rep_release_cnt", cnt, 0);

    // Release mid-delay, then a fresh press
    up = 1'b1;
    run_count("mid_press", 6, 0, cnt, first);
    chk("mid_press_lat", first, 6);
    repeat (9) tick("mid_hold");
    up = 1'b0;
    run_count("mid_delay", 14, 0, cnt, first);
    chk("mid_delay_cnt", cnt, 0);
    up = 1'b1;
    run_count("repress", 26, 0, cnt, first);
    chk("repress_lat", first, 6);
    chk("repress_cnt", cnt, 2);
    up = 1'b0;
    repeat (10) tick("repress_rel");

    // Simultaneous up/down, center pressed mid-repeat
    up = 1'b1; down = 1'b1;
    ucnt = 0; dcnt = 0; ccnt = 0;
    for (int i = 1; i <= 50; i++) begin
      tick("simul");
      chk("simul_same", {31'd0, up_p}, {31'd0, down_p});
      ucnt += int'(up_p); dcnt += int'(down_p); ccnt += int'(ctr_p);
      if (i == 28) ctr = 1'b1;
    end
    chk("simul_up_cnt", ucnt, 5);
    chk("simul_down_cnt", dcnt, 5);
    chk("simul_ctr_cnt", ccnt, 1);
    up = 1'b0; down = 1'b0; ctr = 1'b0;
    repeat (12) tick("simul_rel");

    // Random slow toggling against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) up = ~up;
      if ($urandom_range(0, 11) == 0) down = ~down;
      if ($urandom_range(0, 11) == 0) ctr = ~ctr;
      tick("random");
    end
    up = 1'b0; down = 1'b0; ctr = 1'b0;
    repeat (10) tick("random_rel");

    // Reset mid-repeat with up held through reset
    up = 1'b1;
    repeat (30) tick("pre_reset");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_async", {26'd0, ctr_p, down_p, up_p, bstate}, 32'd0);
    tick("held_in_reset"); tick("held_in_reset");
    rst_n = 1'b1;
    run_count("held_reset", 10, 0, cnt, first);
    chk("held_reset_lat", first, 6);
    chk("held_reset_cnt", cnt, 1);
    up = 1'b0;
    repeat (10) tick("final_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
